// File: rtl/touch_spi_reader.sv
// SPI master for a TSC2046-style resistive touch controller: checks PENIRQ every
// SAMPLE_PERIOD cycles and, on pen-down, runs one X/Y/Z1 scan and publishes a validated sample.
module touch_spi_reader #(
    parameter int          CLK_DIV       = 50,
    parameter int          SAMPLE_PERIOD = 500000,
    parameter logic [11:0] Z_THRESH      = 12'd100
) (
    input  logic        cclk,
    input  logic        rstb,
    input  logic        pen_irqb,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_csb,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y,
    output logic [11:0] touch_z,
    output logic        touch_valid,
    output logic        pen_down,
    output logic        busy
);

    localparam int              HC_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(CLK_DIV - 1);
    localparam logic [23:0]     TMR_LAST = 24'(SAMPLE_PERIOD - 1);
    localparam logic [6:0]      BIT_LAST = 7'd71;
    localparam logic [7:0]      CMD_X    = 8'hD0;
    localparam logic [7:0]      CMD_Y    = 8'h90;
    localparam logic [7:0]      CMD_Z    = 8'hB0;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        UPDATE
    } state_t;

    state_t          state_q, state_d;
    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic [6:0]      bit_cnt_q, bit_cnt_d;
    logic [23:0]     timer_q, timer_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            csb_q, csb_d;
    logic [11:0]     touch_x_q, touch_x_d;
    logic [11:0]     touch_y_q, touch_y_d;
    logic [11:0]     touch_z_q, touch_z_d;
    logic            valid_q, valid_d;
    logic            pen_down_q, pen_down_d;
    logic            busy_q, busy_d;
    logic            pen_meta_q, pen_sync_q;
    logic [11:0]     sh_q, sh_d;
    logic [11:0]     cap_x_q, cap_x_d;
    logic [11:0]     cap_y_q, cap_y_d;
    logic [11:0]     cap_z_q, cap_z_d;
    logic            hc_done;
    logic [1:0]      cur_frame;
    logic [4:0]      cur_pos;

    // Frame index (0=X, 1=Y, 2=Z1) of an overall rising-edge index 0..71.
    function automatic logic [1:0] frame_of(input logic [6:0] idx);
        if (idx >= 7'd48)      frame_of = 2'd2;
        else if (idx >= 7'd24) frame_of = 2'd1;
        else                   frame_of = 2'd0;
    endfunction

    // Zero-based position of an edge inside its 24-clock frame.
    function automatic logic [4:0] pos_of(input logic [6:0] idx);
        logic [6:0] p;
        if (idx >= 7'd48)      p = idx - 7'd48;
        else if (idx >= 7'd24) p = idx - 7'd24;
        else                   p = idx;
        pos_of = p[4:0];
    endfunction

    // MOSI level for rising edge idx: command MSB first on the first 8 edges, then zero.
    function automatic logic cmd_bit(input logic [6:0] idx);
        logic [7:0] cmd;
        logic [4:0] pos;
        case (frame_of(idx))
            2'd0:    cmd = CMD_X;
            2'd1:    cmd = CMD_Y;
            default: cmd = CMD_Z;
        endcase
        pos = pos_of(idx);
        cmd_bit = 1'b0;
        if (idx <= BIT_LAST && pos < 5'd8) cmd_bit = cmd[3'd7 - pos[2:0]];
    endfunction

    assign hc_done   = (hcnt_q == HC_LAST);
    assign cur_frame = frame_of(bit_cnt_q);
    assign cur_pos   = pos_of(bit_cnt_q);

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        csb_d      = csb_q;
        touch_x_d  = touch_x_q;
        touch_y_d  = touch_y_q;
        touch_z_d  = touch_z_q;
        valid_d    = 1'b0;
        pen_down_d = pen_down_q;
        case (state_q)
            IDLE: begin
                timer_d = timer_q + 24'd1;
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if (pen_sync_q) begin
                        pen_down_d = 1'b0;
                    end else begin
                        state_d   = CS_SETUP;
                        csb_d     = 1'b0;
                        sclk_d    = 1'b0;
                        mosi_d    = cmd_bit(7'd0);
                        hcnt_d    = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            CS_SETUP: begin
                hcnt_d = hcnt_q + HC_W'(1);
                if (hc_done) begin
                    hcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hcnt_d = hcnt_q + HC_W'(1);
                if (hc_done) begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: MOSI moves to the bit for the next rising edge.
                        sclk_d = 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = CS_HOLD;
                            bit_cnt_d = '0;
                            mosi_d    = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                            mosi_d    = cmd_bit(bit_cnt_q + 7'd1);
                        end
                    end
                end
            end
            CS_HOLD: begin
                hcnt_d = hcnt_q + HC_W'(1);
                if (hc_done) begin
                    hcnt_d  = '0;
                    csb_d   = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                timer_d = '0;
                if (cap_z_q >= Z_THRESH) begin
                    touch_x_d  = cap_x_q;
                    touch_y_d  = cap_y_q;
                    touch_z_d  = cap_z_q;
                    valid_d    = 1'b1;
                    pen_down_d = 1'b1;
                end else begin
                    pen_down_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                csb_d   = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                timer_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Receive path: MISO is taken on the cclk where SCLK rises, only for edges 10..21.
    always_comb begin
        sh_d    = sh_q;
        cap_x_d = cap_x_q;
        cap_y_d = cap_y_q;
        cap_z_d = cap_z_q;
        if (state_q == SHIFT && hc_done && !sclk_q && cur_pos >= 5'd9 && cur_pos <= 5'd20) begin
            sh_d = {sh_q[10:0], spi_miso};
            if (cur_pos == 5'd20) begin
                case (cur_frame)
                    2'd0:    cap_x_d = sh_d;
                    2'd1:    cap_y_d = sh_d;
                    default: cap_z_d = sh_d;
                endcase
            end
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            csb_q      <= 1'b1;
            touch_x_q  <= '0;
            touch_y_q  <= '0;
            touch_z_q  <= '0;
            valid_q    <= 1'b0;
            pen_down_q <= 1'b0;
            busy_q     <= 1'b0;
            pen_meta_q <= 1'b1;
            pen_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            csb_q      <= csb_d;
            touch_x_q  <= touch_x_d;
            touch_y_q  <= touch_y_d;
            touch_z_q  <= touch_z_d;
            valid_q    <= valid_d;
            pen_down_q <= pen_down_d;
            busy_q     <= busy_d;
            pen_meta_q <= pen_irqb;
            pen_sync_q <= pen_meta_q;
        end
    end

    // Capture registers are always fully rewritten by a completed scan before UPDATE reads them.
    always_ff @(posedge cclk) begin
        sh_q    <= sh_d;
        cap_x_q <= cap_x_d;
        cap_y_q <= cap_y_d;
        cap_z_q <= cap_z_d;
    end

    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign spi_csb     = csb_q;
    assign touch_x     = touch_x_q;
    assign touch_y     = touch_y_q;
    assign touch_z     = touch_z_q;
    assign touch_valid = valid_q;
    assign pen_down    = pen_down_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_touch_spi_reader.sv
// Directed bench for touch_spi_reader with a TSC2046-style controller model on the SPI pins.
module tb_touch_spi_reader;

    localparam int          CLK_DIV       = 4;
    localparam int          SAMPLE_PERIOD = 100;
    localparam logic [11:0] Z_THRESH      = 12'd100;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        pen_irqb = 1'b1;
    logic        spi_miso = 1'b0;
    logic        spi_sclk, spi_mosi, spi_csb;
    logic [11:0] touch_x, touch_y, touch_z;
    logic        touch_valid, pen_down, busy;

    touch_spi_reader #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .Z_THRESH     (Z_THRESH)
    ) dut (
        .cclk       (cclk),
        .rstb       (rstb),
        .pen_irqb   (pen_irqb),
        .spi_miso   (spi_miso),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_csb    (spi_csb),
        .touch_x    (touch_x),
        .touch_y    (touch_y),
        .touch_z    (touch_z),
        .touch_valid(touch_valid),
        .pen_down   (pen_down),
        .busy       (busy)
    );

    always #5 cclk = ~cclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Controller model state and event bookkeeping
    logic [11:0] mx = 12'h0, my = 12'h0, mz = 12'h0;
    int          cyc = 0;
    int          rises = 0;
    logic [23:0] fw = '0;
    int          nfall = 0, nrise = 0, nvalid = 0;
    int          fall_cyc = 0, rise_cyc = 0, valid_cyc = 0, busyfall_cyc = 0;
    logic        busy_seen = 1'b0;
    logic        csb_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0, busy_prev = 1'b0;

    function automatic logic [7:0] exp_cmd(input int f);
        case (f)
            0:       exp_cmd = 8'hD0;
            1:       exp_cmd = 8'h90;
            default: exp_cmd = 8'hB0;
        endcase
    endfunction

    function automatic logic model_bit(input int r);
        int          f, k;
        logic [11:0] d;
        f = r / 24;
        k = (r % 24) + 1;
        d = (f == 0) ? mx : (f == 1) ? my : mz;
        model_bit = 1'b0;
        if (k >= 10 && k <= 21) model_bit = d[21 - k];
    endfunction

    always @(posedge cclk) cyc++;

    always @(negedge cclk) begin
        if (!spi_csb && csb_prev) begin
            nfall++;
            fall_cyc = cyc;
            chk("sclk_at_csb_fall", 32'(spi_sclk), 32'd0);
        end
        if (spi_csb && !csb_prev) begin
            nrise++;
            rise_cyc = cyc;
            if (rstb) begin
                chk("sclk_at_csb_rise", 32'(spi_sclk), 32'd0);
                chk("edges_per_scan", 32'(rises), 32'd72);
            end
        end
        if (busy) busy_seen = 1'b1;
        if (!busy && busy_prev) busyfall_cyc = cyc;
        if (touch_valid) begin
            nvalid++;
            valid_cyc = cyc;
        end
        if (spi_csb) begin
            rises = 0;
            fw    = '0;
        end else if (spi_sclk && !sclk_prev) begin
            chk("mosi_stable", 32'(spi_mosi), 32'(mosi_prev));
            fw = {fw[22:0], spi_mosi};
            rises++;
            if (rises % 24 == 0)
                chk("frame_word", 32'(fw), 32'({exp_cmd(rises / 24 - 1), 16'h0000}));
        end
        if (spi_csb) spi_miso = 1'b0;
        else if (!spi_sclk) spi_miso = model_bit(rises);
        csb_prev  = spi_csb;
        sclk_prev = spi_sclk;
        mosi_prev = spi_mosi;
        busy_prev = busy;
    end

    task automatic wait_valid(input int bound, input string tag);
        int n0, i;
        n0 = nvalid;
        i  = 0;
        while (nvalid == n0 && i < bound) begin
            @(negedge cclk); #1;
            i++;
        end
        chk(tag, 32'(nvalid != n0), 32'd1);
    endtask

    task automatic wait_fall(input int bound, input string tag);
        int n0, i;
        n0 = nfall;
        i  = 0;
        while (nfall == n0 && i < bound) begin
            @(negedge cclk); #1;
            i++;
        end
        chk(tag, 32'(nfall != n0), 32'd1);
    endtask

    task automatic wait_rise(input int bound, input string tag);
        int n0, i;
        n0 = nrise;
        i  = 0;
        while (nrise == n0 && i < bound) begin
            @(negedge cclk); #1;
            i++;
        end
        chk(tag, 32'(nrise != n0), 32'd1);
    endtask

    task automatic chk_xyz(input string tag, input logic [11:0] ex, input logic [11:0] ey,
                           input logic [11:0] ez);
        chk({tag, "_x"}, 32'(touch_x), 32'(ex));
        chk({tag, "_y"}, 32'(touch_y), 32'(ey));
        chk({tag, "_z"}, 32'(touch_z), 32'(ez));
    endtask

    initial begin
        int n0, start, i;

        // Reset state
        repeat (3) @(posedge cclk);
        #1;
        chk("rst_csb", 32'(spi_csb), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_valid", 32'(touch_valid), 32'd0);
        chk("rst_pen_down", 32'(pen_down), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_xyz("rst", 12'h000, 12'h000, 12'h000);
        @(negedge cclk);
        rstb = 1'b1;

        // Pen up at every expiry: no scans
        busy_seen = 1'b0;
        n0 = nfall;
        repeat (350) @(negedge cclk);
        #1;
        chk("penup_no_csb_fall", 32'(nfall), 32'(n0));
        chk("penup_busy_seen", 32'(busy_seen), 32'd0);
        chk("penup_pen_down", 32'(pen_down), 32'd0);
        chk("penup_no_valid", 32'(nvalid), 32'd0);
        chk_xyz("penup", 12'h000, 12'h000, 12'h000);

        // Basic scan, latency and csb width
        mx = 12'hA5C; my = 12'h3F1; mz = 12'h200;
        pen_irqb = 1'b0;
        wait_valid(1000, "t1_valid_seen");
        pen_irqb = 1'b1;
        chk_xyz("t1", 12'hA5C, 12'h3F1, 12'h200);
        chk("t1_latency", 32'(valid_cyc - fall_cyc), 32'd585);
        chk("t1_csb_low", 32'(rise_cyc - fall_cyc), 32'd584);
        chk("t1_pen_down", 32'(pen_down), 32'd1);
        @(negedge cclk); #1;
        chk("t1_valid_one_cycle", 32'(touch_valid), 32'd0);

        // Z1 just below threshold: rejected
        mx = 12'h123; my = 12'h456; mz = 12'd99;
        n0 = nvalid;
        pen_irqb = 1'b0;
        wait_fall(300, "t4a_scan_start");
        pen_irqb = 1'b1;
        wait_rise(800, "t4a_scan_end");
        repeat (3) @(negedge cclk);
        #1;
        chk("t4a_no_valid", 32'(nvalid), 32'(n0));
        chk_xyz("t4a_hold", 12'hA5C, 12'h3F1, 12'h200);
        chk("t4a_pen_down", 32'(pen_down), 32'd0);

        // Z1 exactly at threshold: accepted
        mx = 12'h7E1; my = 12'h0B2; mz = 12'd100;
        pen_irqb = 1'b0;
        wait_valid(1000, "t4b_valid_seen");
        pen_irqb = 1'b1;
        chk_xyz("t4b", 12'h7E1, 12'h0B2, 12'd100);
        chk("t4b_pen_down", 32'(pen_down), 32'd1);

        // PENIRQ toggling during a scan, then back-to-back scan spacing
        mx = 12'h111; my = 12'h222; mz = 12'hFFF;
        pen_irqb = 1'b0;
        wait_fall(300, "t6_scan_start");
        i = 0;
        while (!spi_csb && i < 400) begin
            repeat (3) @(negedge cclk);
            pen_irqb = ~pen_irqb;
            i++;
        end
        pen_irqb = 1'b0;
        chk("t6_csb_released", 32'(spi_csb), 32'd1);
        wait_valid(50, "t6_valid_seen");
        chk_xyz("t6a", 12'h111, 12'h222, 12'hFFF);
        mx = 12'h0F0; my = 12'h00F; mz = 12'h800;
        wait_fall(300, "t6_next_scan");
        chk("t6_spacing", 32'(fall_cyc - busyfall_cyc), 32'(SAMPLE_PERIOD));
        pen_irqb = 1'b1;
        wait_valid(1000, "t6b_valid_seen");
        chk_xyz("t6b", 12'h0F0, 12'h00F, 12'h800);

        // Reset during the Y frame
        mx = 12'h5A5; my = 12'hA5A; mz = 12'h300;
        pen_irqb = 1'b0;
        wait_fall(300, "t5_scan_start");
        i = 0;
        while (!(rises >= 30 && spi_sclk) && i < 600) begin
            @(negedge cclk); #1;
            i++;
        end
        chk("t5_in_y_frame_sclk_high", 32'(spi_sclk), 32'd1);
        #1 rstb = 1'b0;
        #1;
        chk("t5_async_csb", 32'(spi_csb), 32'd1);
        chk("t5_async_sclk", 32'(spi_sclk), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_pen_down", 32'(pen_down), 32'd0);
        chk_xyz("t5_async", 12'h000, 12'h000, 12'h000);
        n0 = nvalid;
        repeat (3) @(negedge cclk);
        rstb = 1'b1;
        start = cyc;
        wait_fall(300, "t5_restart");
        chk("t5_restart_delay", 32'(fall_cyc - start), 32'(SAMPLE_PERIOD));
        chk("t5_no_partial_valid", 32'(nvalid), 32'(n0));
        chk("t5_valid_low", 32'(touch_valid), 32'd0);
        pen_irqb = 1'b1;
        wait_valid(1000, "t5_valid_seen");
        chk_xyz("t5", 12'h5A5, 12'hA5A, 12'h300);

        repeat (5) @(negedge cclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
